axi_mem_responder: RTL and testbench



---
 rtl/axi_mem_responder_pkg.sv | 25 ++
 rtl/cache_bank.sv | 24 ++
 rtl/axi_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_responder_pkg.sv
// Shared AXI constants, widths and responder state encoding for the memory responder.
package axi_mem_responder_pkg;

    localparam int unsigned ADDR_WIDTH    = 32;
    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned AXI_ID_WIDTH  = 4;
    localparam int unsigned AXI_LEN_WIDTH = 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_WRESP,
        S_RWAIT,
        S_RDATA
    } resp_state_e;

    // LEN carries a beat count; zero is treated as a single beat.
    function automatic logic [AXI_LEN_WIDTH-1:0] len_to_beats(input logic [AXI_LEN_WIDTH-1:0] len);
        return (len == '0) ? AXI_LEN_WIDTH'(1) : len;
    endfunction

endpackage

// File: rtl/cache_bank.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
module cache_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI-style single-transaction memory responder serving cache line flushes and refills
// from a word-addressed RAM with programmable read latency.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 12,
    parameter int unsigned READ_LATENCY   = 4,
    parameter string       INIT_FILE      = ""
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [AXI_ID_WIDTH-1:0]  AWID,
    input  logic [AXI_LEN_WIDTH-1:0] AWLEN,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,

    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [AXI_ID_WIDTH-1:0]  WID,
    input  logic [DATA_WIDTH-1:0]    WDATA,
    input  logic                     WLAST,

    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [AXI_ID_WIDTH-1:0]  BID,
    output logic [1:0]               BRESP,

    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]  ARID,
    input  logic [AXI_LEN_WIDTH-1:0] ARLEN,
    input  logic [ADDR_WIDTH-1:0]    ARADDR,

    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [AXI_ID_WIDTH-1:0]  RID,
    output logic [DATA_WIDTH-1:0]    RDATA,
    output logic                     RLAST,
    output logic [1:0]               RRESP
);

    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    resp_state_e                state_q, state_d;
    logic [AXI_ID_WIDTH-1:0]    id_q, id_d;
    logic [MEM_ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [AXI_LEN_WIDTH-1:0]   beats_q, beats_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       err_q, err_d;

    logic                       ram_we;
    logic [DATA_WIDTH-1:0]      ram_rdata;

    // Only the word-index slice of each address is meaningful; the rest aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR, ARADDR};

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        idx_d   = idx_q;
        beats_d = beats_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ram_we  = 1'b0;

        AWREADY = 1'b0;
        ARREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BID     = '0;
        BRESP   = AXI_RESP_OKAY;
        RVALID  = 1'b0;
        RID     = '0;
        RDATA   = '0;
        RLAST   = 1'b0;
        RRESP   = AXI_RESP_OKAY;

        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    // A pending flush wins over a refill so write-before-read order holds.
                    AWREADY = 1'b1;
                    ARREADY = !AWVALID;
                    if (AWVALID) begin
                        id_d    = AWID;
                        idx_d   = AWADDR[2 +: MEM_ADDR_WIDTH];
                        beats_d = len_to_beats(AWLEN);
                        err_d   = 1'b0;
                        state_d = S_WDATA;
                    end else if (ARVALID) begin
                        id_d    = ARID;
                        idx_d   = ARADDR[2 +: MEM_ADDR_WIDTH];
                        beats_d = len_to_beats(ARLEN);
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                        state_d = (READ_LATENCY > 1) ? S_RWAIT : S_RDATA;
                    end
                end

                S_WDATA: begin
                    WREADY = 1'b1;
                    if (WVALID) begin
                        ram_we  = 1'b1;
                        if ((WID != id_q) || (WLAST != (beats_q == AXI_LEN_WIDTH'(1)))) begin
                            err_d = 1'b1;
                        end
                        idx_d   = idx_q + MEM_ADDR_WIDTH'(1);
                        beats_d = beats_q - AXI_LEN_WIDTH'(1);
                        if (beats_q == AXI_LEN_WIDTH'(1)) begin
                            state_d = S_WRESP;
                        end
                    end
                end

                S_WRESP: begin
                    BVALID = 1'b1;
                    BID    = id_q;
                    BRESP  = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    if (BREADY) begin
                        err_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end

                S_RWAIT: begin
                    // RAM is already addressed at idx; its registered output settles here.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_RDATA;
                    end
                end

                S_RDATA: begin
                    RVALID = 1'b1;
                    RID    = id_q;
                    RDATA  = ram_rdata;
                    RLAST  = (beats_q == AXI_LEN_WIDTH'(1));
                    if (RREADY) begin
                        idx_d   = idx_q + MEM_ADDR_WIDTH'(1);
                        beats_d = beats_q - AXI_LEN_WIDTH'(1);
                        if (beats_q == AXI_LEN_WIDTH'(1)) begin
                            state_d = S_IDLE;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            idx_q   <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Read port follows the next index so the word is registered by the time it is shown.
    cache_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_bank (
        .clk   (clk),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (WDATA),
        .raddr (idx_d),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed vector table, corner sequences and
// randomized traffic checked against an associative-array memory model.
module tb_axi_mem_responder;
    import axi_mem_responder_pkg::*;

    localparam int MAW    = 12;
    localparam int LAT    = 4;
    localparam int NWORDS = 1 << MAW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        AWVALID = 0, AWREADY;
    logic [3:0]  AWID = 0, AWLEN = 0;
    logic [31:0] AWADDR = 0;
    logic        WVALID = 0, WREADY, WLAST = 0;
    logic [3:0]  WID = 0;
    logic [31:0] WDATA = 0;
    logic        BVALID, BREADY = 0;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        ARVALID = 0, ARREADY;
    logic [3:0]  ARID = 0, ARLEN = 0;
    logic [31:0] ARADDR = 0;
    logic        RVALID, RREADY = 0, RLAST;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    axi_mem_responder #(
        .MEM_ADDR_WIDTH (MAW),
        .READ_LATENCY   (LAT),
        .INIT_FILE      ("")
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .AWID    (AWID),
        .AWLEN   (AWLEN),
        .AWADDR  (AWADDR),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .WID     (WID),
        .WDATA   (WDATA),
        .WLAST   (WLAST),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BID     (BID),
        .BRESP   (BRESP),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .ARID    (ARID),
        .ARLEN   (ARLEN),
        .ARADDR  (ARADDR),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RID     (RID),
        .RDATA   (RDATA),
        .RLAST   (RLAST),
        .RRESP   (RRESP)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem_m [int];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, want);
    endfunction

    function automatic int word_of(input logic [31:0] addr, input int b);
        return int'(((addr >> 2) + 32'(b)) % NWORDS);
    endfunction

    function automatic int beats_of(input logic [3:0] len);
        return (len == 0) ? 1 : int'(len);
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input int wlast_beat, input bit bad_wid, input logic [31:0] base,
                            input logic [1:0] want_resp, input bit also_ar);
        int beats;
        bit ok;
        logic [31:0] d;
        beats = beats_of(len);
        @(negedge clk);
        AWVALID = 1; AWID = id; AWADDR = addr; AWLEN = len;
        if (also_ar) ARVALID = 1;
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            #1;
            if (ARVALID) chk("ar_blocked_with_aw", ARREADY, 0);
            if (AWREADY) ok = 1;
            else @(negedge clk);
        end
        chk("aw_handshake", ok, 1);
        if (!ok) begin
            AWVALID = 0; ARVALID = 0;
            return;
        end
        @(negedge clk);
        AWVALID = 0;
        for (int b = 0; b < beats; b++) begin
            d = (base != 0) ? base * 32'(b + 1) : $urandom;
            WVALID = 1; WDATA = d; WLAST = (b + 1 == wlast_beat);
            WID = (bad_wid && b == 0) ? (id ^ 4'h1) : id;
            #1;
            chk("wready", WREADY, 1);
            if (ARVALID) chk("ar_blocked_in_w", ARREADY, 0);
            mem_m[word_of(addr, b)] = d;
            @(negedge clk);
        end
        WVALID = 0; WLAST = 0;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            #1;
            if (BVALID) ok = 1;
            else @(negedge clk);
        end
        chk("bvalid", ok, 1);
        if (ok) begin
            chk("bid", BID, id);
            chk("bresp", BRESP, want_resp);
            if (ARVALID) chk("ar_blocked_in_b", ARREADY, 0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); #1;
                chk("bvalid_hold", BVALID, 1);
            end
            BREADY = 1;
            @(posedge clk);
            @(negedge clk);
            BREADY = 0;
            #1;
            chk("bvalid_drop", BVALID, 0);
            if (also_ar) chk("ar_after_b", ARREADY, 1);
        end
        ARVALID = 0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int rr_mode);
        int beats, got, k, t0, w;
        bit ok, first;
        beats = beats_of(len);
        got = 0; k = 0; first = 1;
        @(negedge clk);
        ARVALID = 1; ARID = id; ARADDR = addr; ARLEN = len;
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            #1;
            if (ARREADY) ok = 1;
            else @(negedge clk);
        end
        chk("ar_handshake", ok, 1);
        if (!ok) begin
            ARVALID = 0;
            return;
        end
        t0 = cyc;
        @(negedge clk);
        ARVALID = 0;
        for (int t = 0; t < 300 && got < beats; t++) begin
            case (rr_mode)
                0: RREADY = 1;
                1: RREADY = 1'($urandom_range(0, 1));
                default: RREADY = ((k % 4) == 0) || ((k % 4) == 3);
            endcase
            #1;
            if (RVALID) begin
                if (first) begin
                    chk("read_latency", cyc - t0, LAT);
                    first = 0;
                end
                w = word_of(addr, got);
                if (mem_m.exists(w)) chk("rdata", RDATA, mem_m[w]);
                chk("rlast", RLAST, got == beats - 1);
                chk("rid", RID, id);
                chk("rresp", RRESP, AXI_RESP_OKAY);
                if (RREADY) got++;
                k++;
            end
            @(negedge clk);
        end
        RREADY = 0;
        chk("read_beats", got, beats);
        #1;
        chk("rvalid_done", RVALID, 0);
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        int          wlast;
        bit          bad_wid;
        logic [31:0] base;
        int          rr;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] waddrs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  id, len;
        logic [31:0] addr;
        int wl;
        bit bad;

        vecs.push_back('{1, 4'd3,  32'h40,    4'd4,  4,  0, 32'h11, 0, AXI_RESP_OKAY});
        vecs.push_back('{0, 4'd5,  32'h40,    4'd4,  0,  0, 32'h0,  0, AXI_RESP_OKAY});
        vecs.push_back('{1, 4'd1,  32'h3FFC,  4'd4,  4,  0, 32'h0,  0, AXI_RESP_OKAY});
        vecs.push_back('{0, 4'd2,  32'h3FFC,  4'd4,  0,  0, 32'h0,  0, AXI_RESP_OKAY});
        vecs.push_back('{0, 4'd7,  32'h40,    4'd4,  0,  0, 32'h0,  2, AXI_RESP_OKAY});
        vecs.push_back('{1, 4'd9,  32'h100,   4'd4,  2,  0, 32'h5A, 0, AXI_RESP_SLVERR});
        vecs.push_back('{0, 4'd9,  32'h100,   4'd4,  0,  0, 32'h0,  1, AXI_RESP_OKAY});
        vecs.push_back('{1, 4'd4,  32'h200,   4'd0,  1,  0, 32'hA5, 0, AXI_RESP_OKAY});
        vecs.push_back('{0, 4'd4,  32'h203,   4'd0,  0,  0, 32'h0,  0, AXI_RESP_OKAY});
        vecs.push_back('{1, 4'd6,  32'h10044, 4'd1,  1,  0, 32'h77, 0, AXI_RESP_OKAY});
        vecs.push_back('{0, 4'd6,  32'h44,    4'd2,  0,  0, 32'h0,  0, AXI_RESP_OKAY});
        vecs.push_back('{1, 4'd12, 32'h300,   4'd15, 15, 0, 32'h0,  0, AXI_RESP_OKAY});
        vecs.push_back('{0, 4'd12, 32'h300,   4'd15, 0,  0, 32'h0,  1, AXI_RESP_OKAY});
        vecs.push_back('{1, 4'd8,  32'h400,   4'd3,  0,  0, 32'h0,  0, AXI_RESP_SLVERR});
        vecs.push_back('{1, 4'd8,  32'h500,   4'd2,  2,  1, 32'h0,  0, AXI_RESP_SLVERR});
        vecs.push_back('{0, 4'd8,  32'h500,   4'd2,  0,  0, 32'h0,  2, AXI_RESP_OKAY});

        // Reset state: everything quiet, including the idle readies.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_awready", AWREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_rresp", RRESP, 0);
        chk("rst_rdata", RDATA, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("idle_awready", AWREADY, 1);
        chk("idle_arready", ARREADY, 1);

        foreach (vecs[i]) begin
            if (vecs[i].wr)
                do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].wlast, vecs[i].bad_wid,
                         vecs[i].base, vecs[i].resp, 0);
            else
                do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].rr);
        end

        // Simultaneous AW and AR: write must finish before the read is accepted.
        ARID = 4'd3; ARADDR = 32'h600; ARLEN = 4'd2;
        do_write(4'd10, 32'h600, 4'd2, 2, 0, 32'h0, AXI_RESP_OKAY, 1);
        do_read(4'd3, 32'h600, 4'd2, 0);

        // Reset in the middle of a read burst.
        @(negedge clk);
        ARVALID = 1; ARID = 4'd6; ARADDR = 32'h100; ARLEN = 4'd4;
        #1;
        chk("ar_rst_hs", ARREADY, 1);
        @(negedge clk);
        ARVALID = 0; RREADY = 1;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (RVALID) break;
            @(negedge clk);
        end
        chk("rvalid_before_rst", RVALID, 1);
        @(negedge clk);
        rst = 1; RREADY = 0;
        @(negedge clk);
        #1;
        chk("rvalid_after_rst", RVALID, 0);
        rst = 0;
        @(negedge clk);
        #1;
        chk("rvalid_post_rst", RVALID, 0);
        chk("arready_post_rst", ARREADY, 1);
        do_read(4'd6, 32'h100, 4'd4, 0);

        // Randomized traffic against the memory model.
        for (int i = 0; i < 40; i++) begin
            if (waddrs.size() == 0 || $urandom_range(0, 1) == 1) begin
                addr = $urandom_range(0, NWORDS * 8 - 1);
                len  = 4'($urandom_range(0, 15));
                id   = 4'($urandom);
                bad  = ($urandom_range(0, 9) == 0);
                wl   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : beats_of(len);
                do_write(id, addr, len, wl, bad, 32'h0,
                         (bad || wl != beats_of(len)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY, 0);
                waddrs.push_back(addr);
            end else begin
                addr = waddrs[$urandom_range(0, waddrs.size() - 1)];
                do_read(4'($urandom), addr, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
